// File: rtl/rtc_core_p.sv
// Time-of-day core: BCD hour/min/sec with prescaler, 12/24 h display, set stepping,
// minute-resolution alarm and day-rollover strobe.
module rtc_core_p #(
    parameter int CLK_PER_SEC = 1,
    parameter int RST_HOUR    = 0,
    parameter int RST_MIN     = 0
) (
    input  logic       clk,
    input  logic       sys_rst_p,
    input  logic       tick_en,
    input  logic       mode_12h,
    input  logic       set_time,
    input  logic       set_hour,
    input  logic       set_min,
    input  logic       set_dec,
    input  logic       alarm_en,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_ack,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       pm,
    output logic       sec_tick,
    output logic       day_tick,
    output logic       alarm
);

    localparam int            PW           = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_MAX    = PW'(CLK_PER_SEC - 1);
    localparam logic [7:0]    RST_HOUR_BCD = 8'(((RST_HOUR / 10) * 16) + (RST_HOUR % 10));
    localparam logic [7:0]    RST_MIN_BCD  = 8'(((RST_MIN / 10) * 16) + (RST_MIN % 10));
    localparam logic [7:0]    HOUR_MAX     = 8'h23;
    localparam logic [7:0]    MS_MAX       = 8'h59;

    logic [PW-1:0] presc;
    logic [7:0]    hour24;
    logic [7:0]    min_q;
    logic [7:0]    sec_q;
    logic          set_time_d;
    logic          alarm_q;
    logic          day_q;

    logic          sec_wrap;
    logic          min_wrap;
    logic [7:0]    sec_nxt;
    logic [7:0]    min_nxt;
    logic [7:0]    hour_nxt;
    logic          alarm_valid;
    logic          alarm_hit;
    logic          day_end;

    // BCD +1 with wrap from max_v back to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD -1 with wrap from 00 up to max_v
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        if (v == 8'h00)
            return max_v;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    // 24 h BCD hour to 12 h BCD hour: 00 -> 12, 13..23 -> 01..11
    function automatic logic [7:0] to_12h(input logic [7:0] h);
        logic [4:0] bin;
        logic [4:0] b12;
        bin = ({1'b0, h[7:4]} * 5'd10) + {1'b0, h[3:0]};
        b12 = bin - 5'd12;
        if (h == 8'h00)
            return 8'h12;
        else if (bin <= 5'd12)
            return h;
        else if (b12 >= 5'd10)
            return {4'd1, 4'(b12 - 5'd10)};
        else
            return {4'd0, b12[3:0]};
    endfunction

    assign sec_tick = tick_en & ~set_time & (presc == PRESC_MAX);

    assign sec_wrap = (sec_q == MS_MAX);
    assign min_wrap = (min_q == MS_MAX);
    assign sec_nxt  = bcd_inc(sec_q, MS_MAX);
    assign min_nxt  = sec_wrap ? bcd_inc(min_q, MS_MAX) : min_q;
    assign hour_nxt = (sec_wrap && min_wrap) ? bcd_inc(hour24, HOUR_MAX) : hour24;
    assign day_end  = (hour24 == HOUR_MAX) && min_wrap && sec_wrap;

    // Only normal counting can fire the alarm; set stepping never produces sec_tick
    assign alarm_valid = bcd_in_range(alarm_hour, HOUR_MAX) && bcd_in_range(alarm_min, MS_MAX);
    assign alarm_hit   = sec_tick && alarm_en && alarm_valid &&
                         (hour_nxt == alarm_hour) && (min_nxt == alarm_min) &&
                         (sec_nxt == 8'h00);

    always_ff @(posedge clk) begin
        if (sys_rst_p) begin
            presc      <= '0;
            hour24     <= RST_HOUR_BCD;
            min_q      <= RST_MIN_BCD;
            sec_q      <= 8'h00;
            set_time_d <= 1'b0;
            alarm_q    <= 1'b0;
            day_q      <= 1'b0;
        end else begin
            set_time_d <= set_time;
            day_q      <= sec_tick && day_end;

            if (set_time) begin
                presc <= '0;
                if (!set_time_d)
                    sec_q <= 8'h00;
                if (set_hour)
                    hour24 <= set_dec ? bcd_dec(hour24, HOUR_MAX) : bcd_inc(hour24, HOUR_MAX);
                if (set_min)
                    min_q <= set_dec ? bcd_dec(min_q, MS_MAX) : bcd_inc(min_q, MS_MAX);
            end else if (tick_en) begin
                presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
                if (sec_tick) begin
                    sec_q  <= sec_nxt;
                    min_q  <= min_nxt;
                    hour24 <= hour_nxt;
                end
            end

            // A new match outranks acknowledge on the same edge
            if (alarm_hit)
                alarm_q <= 1'b1;
            else if (alarm_ack || !alarm_en)
                alarm_q <= 1'b0;
        end
    end

    assign hour     = mode_12h ? to_12h(hour24) : hour24;
    assign min      = min_q;
    assign sec      = sec_q;
    assign pm       = (hour24 >= 8'h12);
    assign day_tick = day_q;
    assign alarm    = alarm_q;

endmodule

// File: doc/rtc_core_p.md
Name: rtc_core_p

Overview:
Parametrised time-of-day core, the successor to the fixed 24 h hour/min/sec counter.
- Adds an internal clock-to-second prescaler.
- Adds runtime 12/24 h display mode with PM flag.
- Adds bidirectional set stepping and a minute-resolution alarm with acknowledge.
- Adds a day-rollover strobe.

It feeds the BCD display/scan logic and any calendar block downstream.

Parameters:
CLK_PER_SEC, 1, clk cycles per second tick (>=1); 1 means every enabled clk is a second.
RST_HOUR, 0, reset hour in 24 h decimal (0..23).
RST_MIN, 0, reset minute (0..59).

Ports:
clk  input  1  system clock; all state changes on rising edge.
sys_rst_p  input  1  synchronous, active-high reset.
tick_en  input  1  gates the prescaler; 0 freezes timekeeping.
mode_12h  input  1  display mode: 0 = 24 h, 1 = 12 h.
set_time  input  1  set mode level: 1 = set mode.
set_hour  input  1  one-cycle pulse, step hour (set mode only).
set_min  input  1  one-cycle pulse, step minute (set mode only).
set_dec  input  1  step direction: 0 = +1, 1 = -1.
alarm_en  input  1  alarm enable.
alarm_hour  input  8  alarm hour, BCD, 24 h.
alarm_min  input  8  alarm minute, BCD.
alarm_ack  input  1  clears alarm.
hour  output  8  displayed hour, BCD [7:4] tens, [3:0] units.
min  output  8  minute, BCD.
sec  output  8  second, BCD.
pm  output  1  1 when internal hour >= 12 (valid in both modes).
sec_tick  output  1  second strobe.
day_tick  output  1  registered one-cycle pulse after 23:59:59 -> 00:00:00.
alarm  output  1  alarm level.

Behaviour:
- Reset (sys_rst_p=1 at edge) has priority over every other input.
  - Clears the prescaler to 0.
  - Loads internal hour24=RST_HOUR, min=RST_MIN, sec=00.
  - Clears alarm=0, day_tick=0, and the set_time history register.
- Internal state: hour24, min, sec held as BCD registers. BCD units never exceed 9; units 9 -> 0 carries to tens.
- Prescaler: counts 0..CLK_PER_SEC-1 while tick_en=1 and set_time=0, wraps to 0; holds otherwise.
  - sec_tick is combinational = tick_en & ~set_time & (prescaler==CLK_PER_SEC-1).
  - sec/min/hour update on the same edge where sec_tick=1.
- Normal counting, on a sec_tick edge:
  - sec +1; 59 -> 00.
  - On sec wrap: min +1; 59 -> 00.
  - On min and sec wrap together: hour24 +1; 23 -> 00.
  - 23:59:59 -> 00:00:00 sets day_tick=1 for exactly the next cycle.
- Set mode (set_time=1):
  - Prescaler held at 0 and sec_tick=0.
  - The edge on which set_time is first seen high (0->1 vs registered copy) clears sec to 00 and the prescaler to 0.
  - Each cycle with set_hour=1 steps hour24 by ±1 (set_dec); wraps 23<->00; no effect on min.
  - Each cycle with set_min=1 steps min by ±1; wraps 59<->00; no carry/borrow into hour.
  - set_hour and set_min in the same cycle: both steps apply.
  - set_hour/set_min are ignored when set_time=0.
  - Leaving set mode: counting resumes from prescaler 0, so the first sec_tick comes CLK_PER_SEC enabled cycles later.
- Display mapping is combinational from hour24 and mode_12h, so a mode change is visible the same cycle.
  - mode_12h=0: hour=hour24.
  - mode_12h=1: 00 -> 12; 01..12 -> unchanged; 13..23 -> hour24-12, in BCD.
  - pm = (hour24>=12) regardless of mode.
- Alarm:
  - Sets alarm=1 on the edge where normal counting makes the time equal {alarm_hour, alarm_min, 00} and alarm_en=1.
  - Time reached via set stepping never fires the alarm.
  - A non-BCD or out-of-range alarm_hour/alarm_min never matches.
  - alarm holds until an alarm_ack=1 edge or alarm_en=0 (cleared next edge).
  - A set condition and alarm_ack on the same edge: the set wins.
- Reset mid-set-mode: state goes to reset values. If set_time is still high after reset, that is a new set-mode entry (sec already 00).

Test Plan:
1. CLK_PER_SEC=4, reset, tick_en=1 for 16 cycles -> sec_tick high on cycles 4,8,12,16; sec=0x04; tick_en=0 for 10 cycles -> sec stays 0x04 and the prescaler holds.
2. Set time to 23:59, run to 23:59:59, one more tick -> hour=0x00 min=0x00 sec=0x00; day_tick=1 for exactly one cycle; pm 1->0.
3. mode_12h=1, step hour24 through 00, 11, 12, 13, 23 -> hour=0x12/0x11/0x12/0x01/0x11 with pm=0/0/1/1/1; toggle mode_12h at 13 -> hour=0x13 the same cycle.
4. Time 10:20:35, raise set_time -> sec=0x00 next cycle; set_dec=1, 21 set_min pulses -> min=0x59, hour still 0x10; hour pulses with set_dec=1 from 00 -> 0x23; simultaneous hour+min pulse -> both change.
5. Alarm 06:30 enabled, count 06:29:58 -> 06:30:00 -> alarm=1 on the 06:30:00 edge; alarm_ack -> 0 next edge; set-step to 06:30 -> no alarm; alarm_hour=0x2A -> never fires.
6. Assert sys_rst_p during set mode with alarm=1 and RST_HOUR=7 -> hour=0x07 min=0x00 sec=0x00 alarm=0 day_tick=0 next edge.
